// File: rtl/dec_rn_queue.sv
// -----------------------------------------------------------------------------
// dec_rn_queue
// Multi-lane instruction queue between ID3 and rename. Buffers up to DEPTH
// opaque bundles ({pc, instruction_pack_t, predicted_next_adr}) and moves up to
// LANES bundles in and LANES bundles out per cycle, strict FIFO order with
// lane 0 oldest on both sides.
//
// Optional feature: define DEC_RN_QUEUE_HWM_EN to add the occ_hwm port and
// the occupancy high-water-mark register.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active-high
//   flush      discard all contents (takes effect next cycle)
//   enq_valid  per-lane valid from ID3, lane 0 oldest (contiguous prefix used)
//   enq_data   lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   enq_ready  room for a full LANES group, from start-of-cycle count
//   deq_valid  lane i holds the i-th oldest entry
//   deq_data   oldest entries, lane 0 oldest
//   deq_take   number of entries rename consumes (clamped to count)
//   occupancy  current entry count
//   occ_hwm    high-water mark of occupancy (DEC_RN_QUEUE_HWM_EN only)
// -----------------------------------------------------------------------------
module dec_rn_queue #(
   parameter  int DATA_WIDTH = 128,
   parameter  int LANES      = 2,
   parameter  int DEPTH      = 8,
   localparam int CNT_W      = $clog2(DEPTH + 1),
   localparam int LN_W       = $clog2(LANES + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [LANES-1:0]            enq_valid,
   input  logic [LANES*DATA_WIDTH-1:0] enq_data,
   output logic                        enq_ready,
   output logic [LANES-1:0]            deq_valid,
   output logic [LANES*DATA_WIDTH-1:0] deq_data,
   input  logic [LN_W-1:0]             deq_take,
   output logic [CNT_W-1:0]            occupancy
`ifdef DEC_RN_QUEUE_HWM_EN
   ,
   output logic [CNT_W-1:0]            occ_hwm
`endif
);

   localparam int               PTR_W     = $clog2(DEPTH);
   // Largest start-of-cycle count that still leaves room for a full group.
   localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - LANES);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  w_run;
   logic [LN_W-1:0]       w_n_enq;
   logic [LN_W-1:0]       w_n_enq_acc;
   logic [CNT_W-1:0]      w_take;
   logic [CNT_W-1:0]      w_n_deq;
   logic [CNT_W-1:0]      w_count_nxt;
   logic                  w_enq_ready;

   // Count the contiguous run of valid lanes from lane 0; anything past the
   // first invalid lane is dropped.
   always_comb begin
      w_n_enq = '0;
      w_run   = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         if (w_run && enq_valid[i]) begin
            w_n_enq = w_n_enq + LN_W'(1'b1);
         end else begin
            w_run = 1'b0;
         end
      end
   end

   // Accepted enqueue/dequeue counts and next occupancy; flush cancels both.
   always_comb begin
      w_enq_ready = (r_count <= ENQ_LIMIT);
      w_take      = CNT_W'(deq_take);
      if (flush) begin
         w_n_enq_acc = '0;
         w_n_deq     = '0;
         w_count_nxt = '0;
      end else begin
         w_n_enq_acc = w_enq_ready ? w_n_enq : '0;
         w_n_deq     = (w_take < r_count) ? w_take : r_count;
         w_count_nxt = r_count + CNT_W'(w_n_enq_acc) - w_n_deq;
      end
   end

   // Pointer and count state.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_deq);
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq_acc);
         r_count  <= w_count_nxt;
      end
   end

   // Storage writes; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (!rst && (LN_W'(k) < w_n_enq_acc)) begin
            r_mem[r_wr_ptr + PTR_W'(k)] <= enq_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Dequeue view: oldest LANES entries straight from registered state.
   always_comb begin
      deq_data  = '0;
      deq_valid = '0;
      for (int i = 0; i < LANES; i++) begin
         deq_valid[i]                          = (CNT_W'(i) < r_count);
         deq_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr + PTR_W'(i)];
      end
   end

   assign enq_ready = w_enq_ready;
   assign occupancy = r_count;

`ifdef DEC_RN_QUEUE_HWM_EN
   logic [CNT_W-1:0] r_hwm;

   // High-water mark tracks the next count; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hwm <= '0;
      end else if (w_count_nxt > r_hwm) begin
         r_hwm <= w_count_nxt;
      end else begin
         r_hwm <= r_hwm;
      end
   end

   assign occ_hwm = r_hwm;
`endif

endmodule
